// File: rtl/data_memory.sv
// Single-port byte-lane data memory with fixed-latency load/store responses.
// Define MEM_CLEAR_ON_RESET_EN to zero the array after reset (CLEAR state).
module data_memory #(
  parameter int DEPTH        = 4096,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault
);

  localparam int IW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic          fire;
  logic          fault;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   word;
  logic [31:0]   shifted;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_data;
  logic          clr_en;
  logic [IW-1:0] clr_idx;
  logic          unused_addr;

  assign idx         = req_addr[IW+1:2];
  assign off         = req_addr[1:0];
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:IW+2];
  assign fire        = req_valid && req_ready;
  assign wr_en       = fire && req_write && !fault;

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t        state, state_next;
  logic [IW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    clr_en     = 1'b0;
    req_ready  = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_en = 1'b1;
        if (cnt == IW'(DEPTH - 1)) state_next = READY;
      end
      READY: req_ready = 1'b1;
      default: state_next = CLEAR;
    endcase
  end

  assign clr_idx = cnt;
`else
  assign req_ready = 1'b1;
  assign clr_en    = 1'b0;
  assign clr_idx   = '0;
`endif

  always_comb begin
    unique case (req_size)
      3'b000:  fault = 1'b0;
      3'b100:  fault = req_write;
      3'b001:  fault = off[0];
      3'b101:  fault = off[0] | req_write;
      3'b010:  fault = off != 2'b00;
      default: fault = 1'b1;
    endcase
  end

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    unique case (req_size[1:0])
      2'b00: begin
        be = 4'b0001 << off;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array has no reset; contents survive rst unless the clear pass runs.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  assign word    = mem[idx];
  assign shifted = word >> {off, 3'b000};
  assign ld_b    = shifted[7:0];
  assign ld_h    = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    unique case (req_size)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_data = {24'b0, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_data = {16'b0, ld_h};
      3'b010:  ld_data = word;
      default: ld_data = '0;
    endcase
  end

  logic        v_q [READ_LATENCY];
  logic        f_q [READ_LATENCY];
  logic [31:0] d_q [READ_LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        v_q[i] <= 1'b0;
        f_q[i] <= 1'b0;
        d_q[i] <= '0;
      end
    end else begin
      v_q[0] <= fire;
      f_q[0] <= fire && fault;
      d_q[0] <= (fire && !fault && !req_write) ? ld_data : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign rsp_valid = v_q[READ_LATENCY-1];
  assign rsp_fault = f_q[READ_LATENCY-1];
  assign rsp_rdata = d_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (DEPTH 4096, READ_LATENCY 3).
// Honours MEM_CLEAR_ON_RESET_EN when defined for the build.
module tb_data_memory;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_size = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int checks = 0;
  int failures = 0;

  data_memory #(
    .DEPTH(4096),
    .ADDR_WIDTH(32),
    .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic f,
                     output logic v);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    rd = rsp_rdata;
    f  = rsp_fault;
    v  = rsp_valid;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!req_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_cycles);
  endtask

  logic [31:0] rd;
  logic        f;
  logic        v;
  int          exp_clear;
  logic        exp_rdy;
  logic        ev;
  int          seen;

  initial begin
`ifdef MEM_CLEAR_ON_RESET_EN
    exp_clear = 4096;
    exp_rdy   = 1'b0;
`else
    exp_clear = 0;
    exp_rdy   = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_fault", rsp_fault, 0);
    check("rst_ready", req_ready, exp_rdy);
    rst = 1'b0;
    wait_ready("clear_cycles", exp_clear);

    req(0, 3'b010, 32'h1000, 0, rd, f, v);
    check("lw1000_v", v, 1);
    check("lw1000_f", f, 0);
`ifdef MEM_CLEAR_ON_RESET_EN
    check("lw1000_d", rd, 0);
`endif

    req(1, 3'b010, 32'h0000_3918, 32'h1234_5678, rd, f, v);
    check("sw_pre_v", v, 1);
    check("sw_pre_d", rd, 0);
    req(1, 3'b010, 32'h8542_391A, 32'hdead_beef, rd, f, v);
    check("sw_mis_f", f, 1);
    check("sw_mis_d", rd, 0);
    req(0, 3'b010, 32'h0000_3918, 0, rd, f, v);
    check("sw_mis_keep", rd, 32'h1234_5678);
    req(1, 3'b010, 32'h8542_3918, 32'hdead_beef, rd, f, v);
    check("sw_wrap_f", f, 0);
    req(0, 3'b010, 32'h0000_3918, 0, rd, f, v);
    check("lw_wrap", rd, 32'hdead_beef);

    req(1, 3'b010, 32'h40, 32'h1122_3344, rd, f, v);
    req(1, 3'b000, 32'h41, 32'h0000_00AA, rd, f, v);
    req(0, 3'b010, 32'h40, 0, rd, f, v);
    check("lw40", rd, 32'h1122_AA44);
    req(0, 3'b000, 32'h41, 0, rd, f, v);
    check("lb41", rd, 32'hFFFF_FFAA);
    req(0, 3'b100, 32'h41, 0, rd, f, v);
    check("lbu41", rd, 32'h0000_00AA);
    req(0, 3'b001, 32'h42, 0, rd, f, v);
    check("lh42", rd, 32'h0000_1122);
    req(0, 3'b001, 32'h40, 0, rd, f, v);
    check("lh40", rd, 32'hFFFF_AA44);
    req(0, 3'b101, 32'h40, 0, rd, f, v);
    check("lhu40", rd, 32'h0000_AA44);
    req(1, 3'b001, 32'h42, 32'h0000_BEEF, rd, f, v);
    req(0, 3'b010, 32'h40, 0, rd, f, v);
    check("sh42", rd, 32'hBEEF_AA44);

    req(0, 3'b001, 32'h43, 0, rd, f, v);
    check("lh43_f", f, 1);
    check("lh43_d", rd, 0);
    req(0, 3'b011, 32'h40, 0, rd, f, v);
    check("sz011_f", f, 1);
    req(0, 3'b010, 32'h42, 0, rd, f, v);
    check("lw42_f", f, 1);
    req(1, 3'b100, 32'h40, 32'h0000_0055, rd, f, v);
    check("sbu_f", f, 1);
    req(0, 3'b010, 32'h40, 0, rd, f, v);
    check("sbu_keep", rd, 32'hBEEF_AA44);
    check("sbu_keep_f", f, 0);

    // Store then load to the same word on consecutive edges.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 3'b010;
    req_addr  = 32'h80;
    req_wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    req_write = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    #1;
    check("raw_v", rsp_valid, 1);
    check("raw_d", rsp_rdata, 32'h5A5A_5A5A);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 3'b010;
      req_addr  = 32'h10 + 32'(i * 4);
      req_wdata = 32'((i + 2) * 2);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        ev = (j >= 3) && (j <= 10);
        check($sformatf("tp_v%0d", j), rsp_valid, ev);
        if (ev) begin
          check($sformatf("tp_d%0d", j), rsp_rdata, 32'((j - 1) * 2));
        end
      end
      if (j < 8) begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 3'b010;
        req_addr  = 32'h10 + 32'(j * 4);
      end else begin
        req_valid = 1'b0;
      end
    end

    req(1, 3'b010, 32'h100, 32'hCAFE_F00D, rd, f, v);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 3'b010;
    req_addr  = 32'h100;
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b0;
      if (rsp_valid) seen++;
    end
    check("mid_rst_rsp", seen, 0);
    wait_ready("reclear", (exp_clear == 0) ? 0 : exp_clear - 16);
    req(0, 3'b010, 32'h100, 0, rd, f, v);
`ifdef MEM_CLEAR_ON_RESET_EN
    check("mid_rst_keep", rd, 0);
`else
    check("mid_rst_keep", rd, 32'hCAFE_F00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
